// File: rtl/i2c_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i2c_pkg : shared types and constants for the I2C codec-configuration master
// Rev 1.0
// ---------------------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BITS  = 3'd2,
    ST_STOP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int          SLOT_COUNT   = 27;
  localparam int          BYTES        = 3;
  localparam int          START_Q      = 3;
  localparam int          STOP_Q       = 3;
  localparam int          DATA_W       = 8 * BYTES;
  localparam logic [3:0]  ACK_BIT      = 4'd8;
  localparam logic [7:0]  CODEC_ADDR_W = 8'h34;

endpackage
`default_nettype wire

// File: rtl/i2c_quarter_tick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i2c_quarter_tick : SCL quarter-period divider, tick on last cycle of quarter
// Rev 1.0
// ---------------------------------------------------------------------------
module i2c_quarter_tick #(
  parameter int CLK_DIV = 125
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int             c_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_W-1:0] c_LAST = c_W'(CLK_DIV - 1);

  logic [c_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!i_en || i_clr || (r_cnt == c_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = i_en && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/i2c_xfer_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i2c_xfer_ctrl : bit-level I2C master sending one {addr,reg,data} word per go
// Rev 1.0
// ---------------------------------------------------------------------------
module i2c_xfer_ctrl #(
  parameter int CLK_DIV = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_go,
  input  logic [23:0] i_data,
  input  logic        i_sdat_in,
  output logic        o_sclk,
  output logic        o_sdat_oe,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_ack,
  output logic [1:0]  o_nack_byte,
  inout  wire         io_sda
);

  import i2c_pkg::*;

  state_t              r_state, w_state_n;
  logic [1:0]          r_q, w_q_n;
  logic [3:0]          r_bit, w_bit_n;
  logic [1:0]          r_byte, w_byte_n;
  logic [4:0]          r_slot, w_slot_n;
  logic [DATA_W-1:0]   r_shift, w_shift_n;
  logic                r_busy, w_busy_n;
  logic                r_done, w_done_n;
  logic                r_ack, w_ack_n;
  logic [1:0]          r_nack, w_nack_n;
  logic                r_sclk, w_sclk_n;
  logic                r_oe, w_oe_n;
  logic                w_tick;
  logic                w_en;
  logic                w_clr;

  assign w_en  = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign w_clr = (w_state_n != r_state);

  i2c_quarter_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_qtick (
    .clk    (clk),
    .reset  (reset),
    .i_en   (w_en),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_slot  <= '0;
      r_shift <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ack   <= 1'b0;
      r_nack  <= '0;
      r_sclk  <= 1'b1;
      r_oe    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_q     <= w_q_n;
      r_bit   <= w_bit_n;
      r_byte  <= w_byte_n;
      r_slot  <= w_slot_n;
      r_shift <= w_shift_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
      r_ack   <= w_ack_n;
      r_nack  <= w_nack_n;
      r_sclk  <= w_sclk_n;
      r_oe    <= w_oe_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_q_n     = r_q;
    w_bit_n   = r_bit;
    w_byte_n  = r_byte;
    w_slot_n  = r_slot;
    w_shift_n = r_shift;
    w_busy_n  = r_busy;
    w_done_n  = r_done;
    w_ack_n   = r_ack;
    w_nack_n  = r_nack;
    unique case (r_state)
      ST_IDLE: begin
        if (i_go) begin
          w_state_n = ST_START;
          w_q_n     = '0;
          w_bit_n   = '0;
          w_byte_n  = '0;
          w_slot_n  = '0;
          w_shift_n = i_data;
          w_busy_n  = 1'b1;
          w_ack_n   = 1'b0;
          w_nack_n  = '0;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (r_q == 2'(START_Q - 1)) begin
            w_state_n = ST_BITS;
            w_q_n     = '0;
          end else begin
            w_q_n = r_q + 2'd1;
          end
        end
      end
      ST_BITS: begin
        if (w_tick) begin
          // Ack level is taken on the final clk of the SCL-high sample quarter.
          if ((r_q == 2'd2) && (r_bit == ACK_BIT) && i_sdat_in && (r_nack == 2'd0)) begin
            w_nack_n = r_byte + 2'd1;
          end
          if (r_q != 2'd3) begin
            w_q_n = r_q + 2'd1;
          end else begin
            w_q_n    = '0;
            w_slot_n = r_slot + 5'd1;
            if (r_bit == ACK_BIT) begin
              w_bit_n  = '0;
              w_byte_n = r_byte + 2'd1;
              if ((r_nack != 2'd0) || (r_slot == 5'(SLOT_COUNT - 1))) begin
                w_state_n = ST_STOP;
              end
            end else begin
              w_bit_n   = r_bit + 4'd1;
              w_shift_n = {r_shift[DATA_W-2:0], 1'b0};
            end
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_q == 2'(STOP_Q - 1)) begin
            w_state_n = ST_DONE;
            w_q_n     = '0;
            w_busy_n  = 1'b0;
            w_done_n  = 1'b1;
            w_ack_n   = (r_nack == 2'd0);
          end else begin
            w_q_n = r_q + 2'd1;
          end
        end
      end
      ST_DONE: begin
        if (!i_go) begin
          w_state_n = ST_IDLE;
          w_done_n  = 1'b0;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  // Pin levels are decoded from the next phase so they register on the boundary.
  always_comb begin
    w_sclk_n = 1'b1;
    w_oe_n   = 1'b0;
    unique case (w_state_n)
      ST_START: begin
        w_sclk_n = (w_q_n != 2'd2);
        w_oe_n   = (w_q_n != 2'd0);
      end
      ST_BITS: begin
        w_sclk_n = w_q_n[1];
        w_oe_n   = (w_bit_n != ACK_BIT) && !w_shift_n[DATA_W-1];
      end
      ST_STOP: begin
        w_sclk_n = (w_q_n != 2'd0);
        w_oe_n   = (w_q_n != 2'd2);
      end
      default: begin
        w_sclk_n = 1'b1;
        w_oe_n   = 1'b0;
      end
    endcase
  end

  assign o_sclk      = r_sclk;
  assign o_sdat_oe   = r_oe;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_ack       = r_ack;
  assign o_nack_byte = r_nack;
  assign io_sda      = r_oe ? 1'b0 : 1'bz;

endmodule
`default_nettype wire

// File: doc/i2c_xfer_ctrl.md
# i2c_xfer_ctrl

Bit-level I2C master for the audio-codec configuration path. Serialises one 24-bit word (device address byte, register byte, data byte) onto SCL/SDA per go request, samples the three acknowledge slots, and returns a done/ack handshake. Sits directly downstream of the audio register-load sequencer: consumes its `go`/`data` pair and feeds back `done`/`ack`. Drives the codec I2C pins through a top-level open-drain buffer.

## Interface
- `CLK_DIV`, 125: clk cycles per SCL quarter-period; minimum 1 (125 = 100 kHz SCL at 50 MHz).
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low.
- `go`  in  1  transfer request, level; held by the sequencer until `done`.
- `data`  in  24  {addr byte, reg byte, data byte}, MSB first; latched when the transfer starts.
- `sdat_in`  in  1  sampled SDA pin level.
- `sclk`  out  1  SCL; 1 = released/high.
- `sdat_oe`  out  1  1 = pull SDA low, 0 = release.
- `busy`  out  1  transfer in progress (START through STOP).
- `done`  out  1  transfer finished; held until `go` = 0.
- `ack`  out  1  1 = all transmitted bytes acknowledged; valid while `done` = 1.
- `nack_byte`  out  2  0 = none, 1..3 = first byte that received NACK; valid while `done` = 1.

## Operation
- States: IDLE, START, BITS, STOP, DONE.
- Quarter tick: counter 0..CLK_DIV-1, runs only outside IDLE/DONE, restarts at 0 on each state entry. Each phase below lasts one quarter (CLK_DIV clk cycles).
- IDLE: `sclk`=1, `sdat_oe`=0. On an edge with `go`=1: latch `data` to a shift register, clear ack/nack_byte, set `busy`=1, go to START.
- START (3 quarters): q0 SCL=1 SDA released; q1 SCL=1 SDA low; q2 SCL=0 SDA low.
- BITS: 27 slots (8 data + 1 ack per byte), 4 quarters each: q0 SCL=0, drive SDA (`sdat_oe` = ~bit) or release for the ack slot; q1 SCL=0 hold; q2 SCL=1; q3 SCL=1. Ack slot: `sdat_in` sampled on the last clk of q2; 0 = ACK.
- NACK: record byte number (1..3) in `nack_byte`, set `ack`=0, skip remaining slots, go to STOP after the ack slot completes.
- STOP (3 quarters): q0 SCL=0 SDA low; q1 SCL=1 SDA low; q2 SCL=1 SDA released. Then DONE with `busy`=0, `done`=1, `ack`=1 if `nack_byte`=0.
- DONE: holds `done`/`ack`/`nack_byte`, pins released. When `go`=0: go to IDLE, `done`=0. With `go` still 1, no retrigger.
- `go` while busy: ignored; `data` changes after latch: ignored.
- Asynchronous reset, including mid-transfer: state IDLE, `sclk`=1, `sdat_oe`=0, `busy`=0, `done`=0, `ack`=0, `nack_byte`=0, counters 0. No STOP is generated on reset.

## Timing
- All outputs registered; pins change only on quarter boundaries.
- Full acked transfer: 3 + 108 + 3 = 114 quarters. `busy` rises on edge E, where `go` is sampled in IDLE. `done` rises at E + 114·CLK_DIV.
- NACK on byte n: 3 + 36·n + 3 quarters to `done`.
- `done` falls on the first edge with `go`=0 in DONE. The next `go` is accepted on the following edge at the earliest.
- SDA changes only while SCL=0, except the START/STOP edges.

## Structure
- Shared package `i2c_pkg`: state enum; SLOT_COUNT=27, BYTES=3, START_Q=3, STOP_Q=3; `CODEC_ADDR_W`=8'h34 for benches.
- One sub-module: `i2c_quarter_tick` (CLK_DIV counter with clear). It emits a one-cycle `tick` on the last cycle of each quarter.
- The top level owns the tri-state: SDA = `sdat_oe` ? 0 : Z.

## Test plan
- CLK_DIV=1, `data`=24'h34_001A, slave ACKs all three bytes: `done` at E+114, `ack`=1, `nack_byte`=0; SDA bit stream 0011_0100 / 0000_0000 / 0001_1010 on SCL rising edges.
- Slave NACKs the address byte: `done` at E+42, `ack`=0, `nack_byte`=1, STOP generated, no register/data bits on the bus.
- Slave NACKs the data byte: `done` at E+114, `ack`=0, `nack_byte`=3.
- `go` held high for 50 cycles after `done`: no second START. Drop `go`: `done` clears next edge. Raise `go` again: a new transfer with the new `data` value.
- Reset asserted at slot 10 with SCL low and SDA driven: `sclk`=1, `sdat_oe`=0, `busy`=0 immediately (asynchronous). After release with `go`=1: a clean START.
- CLK_DIV=125: SCL period exactly 500 clk cycles. A SDA transition never coincides with SCL high, except the START/STOP edges.
